// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with a shadow/display register pair
// that is swapped only at frame boundaries, so a frame never mixes old and new values.
// Optional leading-zero blanking is built only when the SEG7_LZB_EN macro is defined.
module seg7_scan #(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    output logic                  ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_tick
);
    localparam int SW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [SW-1:0]       slot_q, slot_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                frame_tick_q, frame_tick_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d, disp_en_q, disp_en_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   eff;
    logic                wrap, last, boundary, accept, on;
    logic [3:0]          nib;

`ifdef SEG7_LZB_EN
    // A digit stays lit only if it or some higher digit is an enabled nonzero; digit 0 always stays.
    always_comb begin
        logic keep;
        keep = 1'b0;
        eff  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            keep   = keep | (disp_en_q[i] && disp_val_q[4*i +: 4] != 4'h0) | (i == 0);
            eff[i] = disp_en_q[i] & keep;
        end
    end
`else
    // Without blanking every enabled digit is shown, leading zeros included.
    always_comb eff = disp_en_q;
`endif

    // Scan counters, load handshake, frame-boundary swap and output decode.
    always_comb begin
        wrap         = slot_q == SW'(CLK_DIV - 1);
        last         = idx_q == IW'(DIGITS - 1);
        boundary     = wrap && last;
        slot_d       = wrap ? '0 : slot_q + 1'b1;
        idx_d        = wrap ? (last ? '0 : idx_q + 1'b1) : idx_q;
        frame_tick_d = slot_d == SW'(CLK_DIV - 1) && idx_d == IW'(DIGITS - 1);
        accept       = load && ready_q;
        sh_val_d     = accept ? value : sh_val_q;
        sh_en_d      = accept ? digit_en : sh_en_q;
        sh_dp_d      = accept ? dp_in : sh_dp_q;
        disp_val_d   = (boundary && !ready_q) ? sh_val_q : disp_val_q;
        disp_en_d    = (boundary && !ready_q) ? sh_en_q : disp_en_q;
        disp_dp_d    = (boundary && !ready_q) ? sh_dp_q : disp_dp_q;
        ready_d      = accept ? 1'b0 : (boundary ? 1'b1 : ready_q);
        nib          = disp_val_q[{idx_q, 2'b00} +: 4];
        on           = eff[idx_q];
        seg_d        = (on ? GLYPH[nib] : 7'h00) ^ {7{ACTIVE_LOW}};
        an_d         = (on ? (DIGITS'(1) << idx_q) : '0) ^ {DIGITS{ACTIVE_LOW}};
        dp_d         = (on & disp_dp_q[idx_q]) ^ ACTIVE_LOW;
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q       <= '0;
            idx_q        <= '0;
            ready_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            sh_val_q     <= '0;
            sh_en_q      <= '0;
            sh_dp_q      <= '0;
            disp_val_q   <= '0;
            disp_en_q    <= '0;
            disp_dp_q    <= '0;
            seg_q        <= {7{ACTIVE_LOW}};
            an_q         <= {DIGITS{ACTIVE_LOW}};
            dp_q         <= ACTIVE_LOW;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            ready_q      <= ready_d;
            frame_tick_q <= frame_tick_d;
            sh_val_q     <= sh_val_d;
            sh_en_q      <= sh_en_d;
            sh_dp_q      <= sh_dp_d;
            disp_val_q   <= disp_val_d;
            disp_en_q    <= disp_en_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign ready      = ready_q;
    assign frame_tick = frame_tick_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan (DIGITS=8, CLK_DIV=4, active-low).
module tb_seg7_scan;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_in = '0, digit_en = '0;
    logic        ready, dp, frame_tick;
    logic [6:0]  seg;
    logic [7:0]  an;

    seg7_scan #(.DIGITS(8), .CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .ready(ready), .value(value),
        .dp_in(dp_in), .digit_en(digit_en), .seg(seg), .an(an), .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [17:0] q[$];
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          t;
    logic [3:0]  m_val [8];
    logic [7:0]  m_en, m_dp, s_en, s_dp;
    logic [31:0] s_val;
    logic        m_pend;

    function automatic bit shown(int i);
        bit lit;
        lit = m_en[i];
`ifdef SEG7_LZB_EN
        if (i != 0) begin
            bit any;
            any = 0;
            for (int j = i; j < 8; j++) if (m_en[j] && m_val[j] != 4'h0) any = 1;
            lit = lit && any;
        end
`endif
        return lit;
    endfunction

    task automatic model_reset();
        t = 0; m_en = '0; m_dp = '0; m_pend = 0; s_val = '0; s_en = '0; s_dp = '0;
        for (int k = 0; k < 8; k++) m_val[k] = '0;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: advance the reference model from pre-edge state, then queue the expected outputs.
    task automatic tick();
        int i;
        bit lit, acc;
        logic [6:0] es;
        logic [7:0] ea;
        logic edp;
        i   = (t / 4) % 8;
        lit = shown(i);
        es  = lit ? ~glyph[m_val[i]] : 7'h7F;
        ea  = lit ? ~(8'd1 << i) : 8'hFF;
        edp = ~(lit && m_dp[i]);
        acc = load && !m_pend;
        if (t % 32 == 31 && m_pend) begin
            for (int k = 0; k < 8; k++) m_val[k] = s_val[4*k +: 4];
            m_en = s_en; m_dp = s_dp; m_pend = 0;
        end
        if (acc) begin
            s_val = value; s_en = digit_en; s_dp = dp_in; m_pend = 1;
        end
        t++;
        @(posedge clk);
        #1;
        q.push_back({!m_pend, (t % 32) == 31, edp, ea, es});
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        q.delete();
        #1 check("reset_outputs", {13'd0, an, seg, dp, ready, frame_tick},
                 {13'd0, 8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0});
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_an(string name, logic [7:0] target, logic [6:0] exp_seg);
        for (int k = 0; k < 64; k++) begin
            tick();
            if (an == target) begin
                check(name, {25'd0, seg}, {25'd0, exp_seg});
                return;
            end
        end
        check({name, "_timeout"}, {24'd0, an}, {24'd0, target});
    endtask

    task automatic do_load(logic [31:0] v, logic [7:0] en, logic [7:0] d);
        value = v; digit_en = en; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Monitor: compare every registered output cycle against the queued expectation.
    always @(negedge clk) begin
        logic [17:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({ready, frame_tick, dp, an, seg} !== e) begin
                errors++;
                $display("FAIL scan t=%0d got %h expected %h", t, {ready, frame_tick, dp, an, seg}, e);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        ticks(5);
        do_load(32'h0000_7F39, 8'hFF, 8'h00);
        ticks(40);
        wait_an("digit0_nine", 8'hFE, 7'b0010000);
        do_load(32'h1234_5678, 8'hFF, 8'h0F);
        value = 32'hFFFF_FFFF; load = 1'b1;
        ticks(3);
        load = 1'b0;
        ticks(70);
        wait_an("digit0_eight", 8'hFE, 7'b0000000);
        while (t % 32 != 31) tick();
        do_load(32'hABCD_EF01, 8'hFF, 8'hA5);
        ticks(80);
        do_load(32'h0000_4321, 8'h0F, 8'hF0);
        ticks(80);
        do_load(32'h0000_0042, 8'hFF, 8'h00);
        ticks(70);
`ifndef SEG7_LZB_EN
        wait_an("digit2_zero", 8'hFB, 7'b1000000);
`endif
        for (int k = 0; k < 400; k++) begin
            value = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
            load = ($urandom_range(0, 7) == 0);
            tick();
        end
        load = 1'b0;
        do_load(32'h9999_9999, 8'hFF, 8'hFF);
        ticks(10);
        do_reset();
        ticks(70);
        for (int k = 0; k < 150; k++) begin
            value = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
            load = ($urandom_range(0, 3) == 0);
            tick();
        end
        load = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
